// File: rtl/uart_fifo_ctrl.sv
// Sequencer between the CPU port decoder and the UART core: TX/RX byte FIFOs plus the
// txbegin/txbusy and rxrecv/data_read handshakes, with RX back-pressure through the receiver WAIT.
module uart_fifo_ctrl #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          wr_stb,
    input  logic          rd_stb,
    output logic [7:0]    rd_data,
    input  logic          fifo_clr,
    output logic [AW:0]   tx_count,
    output logic [AW:0]   rx_count,
    output logic          tx_full,
    output logic          rx_avail,
    output logic          tx_idle,
    output logic          tx_ovf,
    output logic [7:0]    u_txdata,
    output logic          u_txbegin,
    input  logic          u_txbusy,
    input  logic [7:0]    u_rxdata,
    input  logic          u_rxrecv,
    output logic          u_data_read
);
    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_WAITB, T_WAITD} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_PUSH, R_ACK} rx_state_e;

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [AW:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          tx_ovf_q;
    logic [7:0]    u_txdata_q;
    logic          u_txbegin_q, u_data_read_q;
    tx_state_e     tx_state_q;
    rx_state_e     rx_state_q;
    logic          tx_full_w, rx_full_w;
    logic          tx_pop, tx_push, tx_drop, rx_pop, rx_push;

    // A full FIFO still accepts a push when its head leaves in the same cycle; clear beats everything.
    always_comb begin
        tx_full_w = (tx_count_q == CNT_FULL);
        rx_full_w = (rx_count_q == CNT_FULL);
        tx_pop    = (tx_state_q == T_IDLE) && (tx_count_q != '0) && !u_txbusy && !fifo_clr;
        tx_push   = wr_stb && !fifo_clr && (!tx_full_w || tx_pop);
        tx_drop   = wr_stb && !fifo_clr && tx_full_w && !tx_pop;
        rx_pop    = rd_stb && (rx_count_q != '0) && !fifo_clr;
        rx_push   = (rx_state_q == R_PUSH) && !fifo_clr && (!rx_full_w || rx_pop);

        tx_count_d = tx_count_q;
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count_q + CNT_ONE;
        end else if (tx_pop && !tx_push) begin
            tx_count_d = tx_count_q - CNT_ONE;
        end

        rx_count_d = rx_count_q;
        if (rx_push && !rx_pop) begin
            rx_count_d = rx_count_q + CNT_ONE;
        end else if (rx_pop && !rx_push) begin
            rx_count_d = rx_count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
        end else if (fifo_clr) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
            if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            if (tx_drop) tx_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= wr_data;
        if (rx_push) rx_mem_q[rx_wptr_q] <= u_rxdata;
    end

    // Reset does not reach the UART core, so a frame in flight is simply forgotten here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= T_IDLE;
            u_txdata_q  <= 8'h00;
            u_txbegin_q <= 1'b0;
        end else begin
            case (tx_state_q)
                T_IDLE: begin
                    if (tx_pop) begin
                        u_txdata_q  <= tx_mem_q[tx_rptr_q];
                        u_txbegin_q <= 1'b1;
                        tx_state_q  <= T_START;
                    end
                end
                T_START: begin
                    u_txbegin_q <= 1'b0;
                    tx_state_q  <= T_WAITB;
                end
                T_WAITB: begin
                    if (u_txbusy) tx_state_q <= T_WAITD;
                end
                T_WAITD: begin
                    if (!u_txbusy) tx_state_q <= T_IDLE;
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    // Holding off the acknowledge keeps the receiver in WAIT, which keeps its RTS asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q    <= R_IDLE;
            u_data_read_q <= 1'b0;
        end else begin
            case (rx_state_q)
                R_IDLE: begin
                    if (u_rxrecv) rx_state_q <= R_PUSH;
                end
                R_PUSH: begin
                    if (rx_push) begin
                        u_data_read_q <= 1'b1;
                        rx_state_q    <= R_ACK;
                    end
                end
                R_ACK: begin
                    u_data_read_q <= 1'b0;
                    rx_state_q    <= R_IDLE;
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    assign rd_data     = (rx_count_q == '0) ? 8'hFF : rx_mem_q[rx_rptr_q];
    assign tx_count    = tx_count_q;
    assign rx_count    = rx_count_q;
    assign tx_full     = tx_full_w;
    assign rx_avail    = (rx_count_q != '0);
    assign tx_idle     = (tx_count_q == '0) && (tx_state_q == T_IDLE);
    assign tx_ovf      = tx_ovf_q;
    assign u_txdata    = u_txdata_q;
    assign u_txbegin   = u_txbegin_q;
    assign u_data_read = u_data_read_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: queue-based reference model, transmitter/receiver stubs,
// directed scenarios with literal expectations, then a randomized run.
module tb_uart_fifo_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk, reset;
    logic [7:0]    wr_data, rd_data, u_txdata, u_rxdata;
    logic          wr_stb, rd_stb, fifo_clr;
    logic [AW:0]   tx_count, rx_count;
    logic          tx_full, rx_avail, tx_idle, tx_ovf;
    logic          u_txbegin, u_txbusy, u_rxrecv, u_data_read;

    uart_fifo_ctrl #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_stb(wr_stb), .rd_stb(rd_stb),
        .rd_data(rd_data), .fifo_clr(fifo_clr), .tx_count(tx_count), .rx_count(rx_count),
        .tx_full(tx_full), .rx_avail(rx_avail), .tx_idle(tx_idle), .tx_ovf(tx_ovf),
        .u_txdata(u_txdata), .u_txbegin(u_txbegin), .u_txbusy(u_txbusy),
        .u_rxdata(u_rxdata), .u_rxrecv(u_rxrecv), .u_data_read(u_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: byte queues plus a few flags describing the handshakes.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         mOvf, mActive, mBeginExp, mSeenBusy, mPending, mAck;
    bit         mLaunch, mRdPop, mDoPush;
    logic [7:0] mTxData = 8'h00;

    // Stub state for the UART core on both sides.
    int         busyCnt = 0;
    bit         stall = 0, prevBusy = 0;
    int         tickNo = 0;
    logic [7:0] sent[$];
    int         beginTick[$];
    int         fallTick[$];
    logic [7:0] rxReqQ[$];
    bit         rxWaiting = 0;
    int         rxCool = 0;
    int         ackCount = 0;

    bit expBits[16] = '{1,0,1,0,1,0,1,0, 1,1,0,0,0,1,0,1};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            txq.delete();
            rxq.delete();
            mOvf = 0; mActive = 0; mBeginExp = 0; mSeenBusy = 0;
            mPending = 0; mAck = 0; mTxData = 8'h00;
        end else begin
            mLaunch = !mActive && txq.size() > 0 && !u_txbusy && !fifo_clr;
            if (mLaunch) begin
                mTxData = txq.pop_front();
                mActive = 1; mBeginExp = 1; mSeenBusy = 0;
            end else if (mActive) begin
                if (mBeginExp) mBeginExp = 0;
                else if (!mSeenBusy) begin
                    if (u_txbusy) mSeenBusy = 1;
                end else if (!u_txbusy) mActive = 0;
            end
            if (fifo_clr) begin
                txq.delete();
                mOvf = 0;
            end else if (wr_stb) begin
                if (txq.size() < DEPTH) txq.push_back(wr_data);
                else mOvf = 1;
            end

            mRdPop  = rd_stb && rxq.size() > 0 && !fifo_clr;
            mDoPush = 0;
            if (mAck) mAck = 0;
            else if (mPending) begin
                if (!fifo_clr && (rxq.size() < DEPTH || mRdPop)) begin
                    mDoPush = 1; mPending = 0; mAck = 1;
                end
            end else if (u_rxrecv) mPending = 1;
            if (fifo_clr) rxq.delete();
            else begin
                if (mRdPop) void'(rxq.pop_front());
                if (mDoPush) rxq.push_back(u_rxdata);
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("tx_count", 32'(tx_count), 32'(txq.size()));
        checkVal("rx_count", 32'(rx_count), 32'(rxq.size()));
        checkVal("tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
        checkVal("rx_avail", 32'(rx_avail), 32'(rxq.size() != 0));
        checkVal("tx_idle", 32'(tx_idle), 32'(txq.size() == 0 && !mActive));
        checkVal("tx_ovf", 32'(tx_ovf), 32'(mOvf));
        checkVal("u_txdata", 32'(u_txdata), 32'(mTxData));
        checkVal("u_txbegin", 32'(u_txbegin), 32'(mBeginExp));
        checkVal("u_data_read", 32'(u_data_read), 32'(mAck));
        checkVal("rd_data", 32'(rd_data), (rxq.size() > 0) ? 32'(rxq[0]) : 32'hFF);
    endtask

    task automatic checkResetValues();
        checkVal("rst_tx_count", 32'(tx_count), 32'h0);
        checkVal("rst_rx_count", 32'(rx_count), 32'h0);
        checkVal("rst_tx_full", 32'(tx_full), 32'h0);
        checkVal("rst_rx_avail", 32'(rx_avail), 32'h0);
        checkVal("rst_tx_idle", 32'(tx_idle), 32'h1);
        checkVal("rst_tx_ovf", 32'(tx_ovf), 32'h0);
        checkVal("rst_u_txdata", 32'(u_txdata), 32'h0);
        checkVal("rst_u_txbegin", 32'(u_txbegin), 32'h0);
        checkVal("rst_u_data_read", 32'(u_data_read), 32'h0);
        checkVal("rst_rd_data", 32'(rd_data), 32'hFF);
    endtask

    // One cycle: compare at the falling edge, drop strobes, then let the core stubs react.
    task automatic nextCycle();
        @(negedge clk);
        tickNo++;
        checkOutput();
        wr_stb = 0; rd_stb = 0; fifo_clr = 0; u_rxrecv = 0;
        if (u_txbegin === 1'b1) begin
            sent.push_back(u_txdata);
            beginTick.push_back(tickNo);
            busyCnt = $urandom_range(6, 2);
        end
        if (busyCnt > 0) begin
            u_txbusy = 1'b1;
            busyCnt--;
        end else u_txbusy = stall;
        if (prevBusy && !u_txbusy) fallTick.push_back(tickNo);
        prevBusy = u_txbusy;
        if (u_data_read === 1'b1) ackCount++;
        if (rxWaiting && u_data_read === 1'b1) begin
            rxWaiting = 0;
            rxCool = 1;
        end else if (rxCool > 0) rxCool--;
        else if (!rxWaiting && rxReqQ.size() > 0) begin
            u_rxdata = rxReqQ.pop_front();
            u_rxrecv = 1'b1;
            rxWaiting = 1;
        end
    endtask

    task automatic applyStimulus();
        if ($urandom_range(99, 0) < 30) begin
            wr_stb = 1'b1;
            wr_data = 8'($urandom);
        end
        if ($urandom_range(99, 0) < 25) rd_stb = 1'b1;
        if ($urandom_range(199, 0) == 0) fifo_clr = 1'b1;
        if ($urandom_range(99, 0) < 3) stall = !stall;
        if (rxReqQ.size() < 4 && $urandom_range(99, 0) < 20) rxReqQ.push_back(8'($urandom));
    endtask

    task automatic waitTxDrained(input int budget);
        int n = 0;
        while (!(tx_idle === 1'b1 && u_txbusy === 1'b0) && n < budget) begin
            nextCycle();
            n++;
        end
        if (n >= budget) checkVal("tx_drain_timeout", 32'(n), 32'(budget - 1));
    endtask

    task automatic waitAck(input int budget);
        int start = ackCount;
        int n = 0;
        while (ackCount == start && n < budget) begin
            nextCycle();
            n++;
        end
        if (n >= budget) checkVal("ack_timeout", 32'(n), 32'(budget - 1));
    endtask

    function automatic logic [7:0] sentAt(input int i);
        return (i >= 0 && i < sent.size()) ? sent[i] : 8'hxx;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b0, f0, s0, a0, n;
        logic [7:0] sb;
        bit gapOk;
        reset = 0; wr_data = 0; wr_stb = 0; rd_stb = 0; fifo_clr = 0;
        u_txbusy = 0; u_rxdata = 0; u_rxrecv = 0;
        #1 reset = 1;
        #1 checkResetValues();
        nextCycle();
        nextCycle();
        reset = 0;

        $display("[TB] two back-to-back bytes");
        b0 = beginTick.size(); f0 = fallTick.size(); s0 = sent.size();
        wr_data = 8'h55; wr_stb = 1; nextCycle();
        wr_data = 8'hA3; wr_stb = 1; nextCycle();
        waitTxDrained(200);
        checkVal("frames_sent", 32'(sent.size() - s0), 32'd2);
        checkVal("begin_pulses", 32'(beginTick.size() - b0), 32'd2);
        for (int i = 0; i < 16; i++) begin
            sb = sentAt(s0 + i / 8);
            checkVal("line_bit", 32'(sb[i % 8]), 32'(expBits[i]));
        end
        gapOk = (beginTick.size() >= b0 + 2 && fallTick.size() > f0) ?
                (beginTick[b0 + 1] > fallTick[f0]) : 1'b0;
        checkVal("second_begin_after_busy_fall", 32'(gapOk), 32'd1);

        $display("[TB] TX overflow while stalled");
        s0 = sent.size();
        stall = 1; nextCycle();
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(8'h10 + i); wr_stb = 1; nextCycle();
        end
        checkVal("ovf_tx_count", 32'(tx_count), 32'd16);
        checkVal("ovf_tx_full", 32'(tx_full), 32'd1);
        checkVal("ovf_tx_ovf", 32'(tx_ovf), 32'd1);
        stall = 0;
        waitTxDrained(400);
        checkVal("ovf_frames_sent", 32'(sent.size() - s0), 32'd16);
        checkVal("ovf_last_byte", 32'(sentAt(sent.size() - 1)), 32'h1F);
        checkVal("ovf_sticky", 32'(tx_ovf), 32'd1);
        stall = 1; nextCycle();
        wr_data = 8'hEE; wr_stb = 1; nextCycle();
        wr_stb = 1; nextCycle();
        fifo_clr = 1; nextCycle();
        checkVal("clr_tx_ovf", 32'(tx_ovf), 32'd0);
        checkVal("clr_tx_count", 32'(tx_count), 32'd0);
        stall = 0; nextCycle(); nextCycle();

        $display("[TB] single RX byte");
        a0 = ackCount;
        rxReqQ.push_back(8'h3C);
        waitAck(50);
        checkVal("rx1_count", 32'(rx_count), 32'd1);
        checkVal("rx1_data", 32'(rd_data), 32'h3C);
        repeat (4) nextCycle();
        checkVal("rx1_acks", 32'(ackCount - a0), 32'd1);
        rd_stb = 1; nextCycle();
        checkVal("rx1_pop_count", 32'(rx_count), 32'd0);
        checkVal("rx1_pop_data", 32'(rd_data), 32'hFF);

        $display("[TB] RX back-pressure");
        for (int i = 0; i < 16; i++) rxReqQ.push_back(8'(8'h40 + i));
        n = 0;
        while (rx_count !== 5'd16 && n < 300) begin
            nextCycle();
            n++;
        end
        if (n >= 300) checkVal("rx_fill_timeout", 32'(n), 32'd299);
        a0 = ackCount;
        rxReqQ.push_back(8'h99);
        repeat (10) nextCycle();
        checkVal("bp_rts_held", 32'(rxWaiting), 32'd1);
        checkVal("bp_no_ack", 32'(ackCount - a0), 32'd0);
        checkVal("bp_count", 32'(rx_count), 32'd16);
        rd_stb = 1; nextCycle();
        checkVal("bp_ack_next", 32'(u_data_read), 32'd1);
        checkVal("bp_count_after", 32'(rx_count), 32'd16);
        checkVal("bp_head_after", 32'(rd_data), 32'h41);
        repeat (15) begin
            rd_stb = 1; nextCycle();
        end
        checkVal("bp_last_byte", 32'(rd_data), 32'h99);
        rd_stb = 1; nextCycle();

        $display("[TB] reset while waiting for busy to fall");
        b0 = beginTick.size();
        wr_data = 8'hC3; wr_stb = 1; nextCycle();
        n = 0;
        while (beginTick.size() == b0 && n < 20) begin
            nextCycle();
            n++;
        end
        if (n >= 20) checkVal("begin_timeout", 32'(n), 32'd19);
        stall = 1;
        repeat (4) nextCycle();
        reset = 1;
        #1 checkResetValues();
        nextCycle(); nextCycle();
        reset = 0;
        b0 = beginTick.size();
        repeat (5) nextCycle();
        stall = 0;
        repeat (5) nextCycle();
        checkVal("no_begin_after_reset", 32'(beginTick.size() - b0), 32'd0);
        wr_data = 8'h5A; wr_stb = 1; nextCycle();
        waitTxDrained(100);
        checkVal("begin_after_write", 32'(beginTick.size() - b0), 32'd1);
        checkVal("byte_after_reset", 32'(sentAt(sent.size() - 1)), 32'h5A);

        $display("[TB] push and pop together on a full TX FIFO");
        s0 = sent.size();
        stall = 1; nextCycle();
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(8'h60 + i); wr_stb = 1; nextCycle();
        end
        checkVal("full_count", 32'(tx_count), 32'd16);
        stall = 0; u_txbusy = 0;
        wr_data = 8'h77; wr_stb = 1; nextCycle();
        checkVal("swap_count", 32'(tx_count), 32'd16);
        checkVal("swap_ovf", 32'(tx_ovf), 32'd0);
        checkVal("swap_begin", 32'(u_txbegin), 32'd1);
        checkVal("swap_txdata", 32'(u_txdata), 32'h60);
        waitTxDrained(400);
        checkVal("swap_frames", 32'(sent.size() - s0), 32'd17);
        checkVal("swap_last", 32'(sentAt(sent.size() - 1)), 32'h77);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            nextCycle();
        end
        stall = 0;
        rxReqQ.delete();
        repeat (60) begin
            rd_stb = 1; nextCycle();
        end
        waitTxDrained(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Sequencer between the CPU port decoder and the UART core (txbegin/txbusy and rxrecv/data_read handshakes).
- Buffers outgoing bytes in a TX FIFO and feeds them to the transmitter one at a time.
- Stores received bytes in an RX FIFO and releases the receiver's WAIT state only when there is space. This turns the receiver's RTS into real flow control.

Parameters:
AW, 4, FIFO address width; each FIFO holds 2**AW entries (16).

Ports:
clk  in  1  system clock, same clock as the UART core
reset  in  1  asynchronous, active-high reset
wr_data  in  8  CPU byte to transmit
wr_stb  in  1  one-cycle strobe: push wr_data into the TX FIFO
rd_stb  in  1  one-cycle strobe: pop the RX FIFO head
rd_data  out  8  RX FIFO head (first-word fall-through); 8'hFF when empty
fifo_clr  in  1  synchronous clear of both FIFOs and the sticky flags
tx_count  out  AW+1  TX FIFO occupancy
rx_count  out  AW+1  RX FIFO occupancy
tx_full  out  1  tx_count == 2**AW
rx_avail  out  1  rx_count != 0
tx_idle  out  1  TX FIFO empty and TX FSM in T_IDLE
tx_ovf  out  1  sticky: write attempted while TX FIFO full
u_txdata  out  8  byte to the UART transmitter
u_txbegin  out  1  start pulse to the transmitter
u_txbusy  in  1  transmitter busy
u_rxdata  in  8  receiver data (stable while the receiver waits)
u_rxrecv  in  1  one-cycle pulse: byte received
u_data_read  out  1  acknowledge to the receiver, releases its WAIT state

Behaviour:
Reset (async, reset=1):
- FIFOs empty, counts 0, tx_ovf 0.
- u_txbegin 0, u_data_read 0, u_txdata 8'h00.
- rd_data 8'hFF, tx_full 0, rx_avail 0, tx_idle 1.
- Both FSMs go to their idle state.
- Reset asserted mid-frame aborts the handshake. The core is not reset by this block, so after release the TX FSM re-enters T_IDLE and only issues u_txbegin when u_txbusy=0.

FIFOs:
- Circular buffers with AW-bit pointers that wrap at 2**AW; the count is kept separately.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- Push when full: dropped. For TX this sets tx_ovf.
- Pop when empty: ignored.
- fifo_clr has priority over every push/pop in the same cycle. It does not abort a transmission already started.

TX FSM:
- T_IDLE: if the TX FIFO is not empty and u_txbusy=0, pop the head into u_txdata and go to T_START.
- T_START: u_txbegin=1 for exactly this one cycle, then go to T_WAITB.
- T_WAITB: u_txbegin=0. When u_txbusy=1, go to T_WAITD.
- T_WAITD: when u_txbusy=0, go to T_IDLE.
- u_txdata holds its value from the pop until the return to T_IDLE.
- Minimum gap between frames: 1 cycle after u_txbusy falls.

RX FSM:
- R_IDLE: on u_rxrecv=1, go to R_PUSH.
- R_PUSH: if the RX FIFO is not full, or a rd_stb pop happens this cycle, push u_rxdata and go to R_ACK. Otherwise stay; u_data_read stays 0 so the receiver holds RTS.
- R_ACK: u_data_read=1 for exactly this one cycle, then go to R_IDLE.
- u_rxrecv arriving outside R_IDLE cannot occur, because the receiver is held in WAIT. Ignore it.
- Latency: the byte is visible on rd_data 2 cycles after u_rxrecv when the FIFO has space.

Outputs:
- All outputs are registered except rd_data, tx_full, rx_avail and tx_idle, which are decoded from registers.

Test Plan:
- Write 8'h55, 8'hA3 back-to-back with an idle model → two frames. u_txbegin pulses exactly once per byte, the second only after u_txbusy falls. Line bits are LSB first: 1,0,1,0,1,0,1,0 then 1,1,0,0,0,1,0,1.
- Write 17 bytes while the transmitter is stalled busy → tx_count 16, tx_full 1, tx_ovf 1. The 17th byte is never sent. fifo_clr → tx_ovf 0, tx_count 0.
- Receiver model delivers 8'h3C → rx_count 1, rd_data 8'h3C, u_data_read pulses once. rd_stb → rx_count 0, rd_data 8'hFF.
- Fill the RX FIFO with 16 bytes, then deliver a 17th (8'h99) → u_data_read stays 0 and the model's RTS stays high. One rd_stb → 8'h99 pushed in the same cycle, u_data_read pulses the next cycle, rx_count 16.
- Assert reset while in T_WAITD → all outputs at reset values immediately. After release with u_txbusy still 1, no u_txbegin until u_txbusy falls and a new byte is written.
- Simultaneous wr_stb and a TX pop when tx_count=16 → count stays 16, no overflow flagged.
